// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_pkg: register map, control bit positions and hex font
// shared by the 7-segment scan controller and its timer.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [31:0] DIG0_OFS = 32'h00;
    localparam logic [31:0] DIG1_OFS = 32'h04;
    localparam logic [31:0] DIG2_OFS = 32'h08;
    localparam logic [31:0] DIG3_OFS = 32'h0C;
    localparam logic [31:0] CTRL_OFS = 32'h10;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_BRIGHT_LO = 1;
    localparam int CTRL_BRIGHT_HI = 3;
    localparam int CTRL_HEX       = 4;

    localparam logic [2:0] BRIGHT_RST = 3'd7;

    // Segments g..a, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: MCS IO-bus signals between the bus master
// and the 7-segment display peripheral.
interface seg7_scan_ctrl_if;

    logic [31:0] IO_Address;
    logic        IO_Addr_Strobe;
    logic [3:0]  IO_Byte_Enable;
    logic [31:0] IO_Write_Data;
    logic        IO_Write_Strobe;
    logic        IO_Read_Strobe;
    logic [31:0] IO_Read_Data;
    logic        IO_Ready;

    modport master (
        output IO_Address,
        output IO_Addr_Strobe,
        output IO_Byte_Enable,
        output IO_Write_Data,
        output IO_Write_Strobe,
        output IO_Read_Strobe,
        input  IO_Read_Data,
        input  IO_Ready
    );

    modport slave (
        input  IO_Address,
        input  IO_Addr_Strobe,
        input  IO_Byte_Enable,
        input  IO_Write_Data,
        input  IO_Write_Strobe,
        input  IO_Read_Strobe,
        output IO_Read_Data,
        output IO_Ready
    );

endinterface

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: digit-slot prescaler, digit index and the
// PWM brightness gate for the multiplexed display.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int SCAN_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       bright,
    output logic [IDX_W-1:0] idx,
    output logic             lit
);

    logic [SCAN_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Top three prescaler bits form an 8-step PWM phase per slot.
    assign lit = en && (cnt[SCAN_BITS-1 -: 3] <= bright);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: IO-bus 4-digit multiplexed 7-segment controller.
// Define SEG7_HEX_DECODE_EN to add the CTRL.HEX font decode.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hc000_0000,
    parameter int          SCAN_BITS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    seg7_scan_ctrl_if.slave bus,
    output logic [7:0]      nSEG,
    output logic [3:0]      nAN
);

    logic [7:0]       dig [NUM_DIGITS];
    logic             en;
    logic [2:0]       bright;
    logic             hex;
    logic [31:0]      ofs;
    logic             wr;
    logic             rd;
    logic             acc;
    logic [31:0]      rdata;
    logic [IDX_W-1:0] idx;
    logic             lit;
    logic [7:0]       pat;
    logic             unused;

    assign ofs = bus.IO_Address - BASE_ADDR;
    assign acc = bus.IO_Addr_Strobe
               & (bus.IO_Read_Strobe | bus.IO_Write_Strobe);
    assign rd  = bus.IO_Addr_Strobe & bus.IO_Read_Strobe;
    assign wr  = bus.IO_Addr_Strobe & bus.IO_Write_Strobe
               & bus.IO_Byte_Enable[0];

    assign unused = ^{bus.IO_Write_Data, bus.IO_Byte_Enable};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig[i] <= '0;
            end
            en     <= 1'b0;
            bright <= BRIGHT_RST;
        end else if (wr) begin
            case (ofs)
                DIG0_OFS: dig[0] <= bus.IO_Write_Data[7:0];
                DIG1_OFS: dig[1] <= bus.IO_Write_Data[7:0];
                DIG2_OFS: dig[2] <= bus.IO_Write_Data[7:0];
                DIG3_OFS: dig[3] <= bus.IO_Write_Data[7:0];
                CTRL_OFS: begin
                    en     <= bus.IO_Write_Data[CTRL_EN];
                    bright <= bus.IO_Write_Data[CTRL_BRIGHT_HI:CTRL_BRIGHT_LO];
                end
                default: ;
            endcase
        end
    end

`ifdef SEG7_HEX_DECODE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hex <= 1'b0;
        end else if (wr && ofs == CTRL_OFS) begin
            hex <= bus.IO_Write_Data[CTRL_HEX];
        end
    end
`else
    assign hex = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (ofs)
            DIG0_OFS: rdata[7:0] = dig[0];
            DIG1_OFS: rdata[7:0] = dig[1];
            DIG2_OFS: rdata[7:0] = dig[2];
            DIG3_OFS: rdata[7:0] = dig[3];
            CTRL_OFS: rdata[CTRL_HEX:0] = {hex, bright, en};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.IO_Ready     <= 1'b0;
            bus.IO_Read_Data <= '0;
        end else begin
            bus.IO_Ready <= acc;
            if (rd) begin
                bus.IO_Read_Data <= rdata;
            end
        end
    end

    seg7_scan_timer #(
        .SCAN_BITS(SCAN_BITS)
    ) u_timer (
        .clk   (CLK),
        .rst   (RST),
        .en    (en),
        .bright(bright),
        .idx   (idx),
        .lit   (lit)
    );

    always_comb begin
        pat = dig[idx];
`ifdef SEG7_HEX_DECODE_EN
        if (hex) begin
            pat = {dig[idx][7], HEX_FONT[dig[idx][3:0]]};
        end
`endif
    end

    // Registered drivers keep the anode/segment edges glitch-free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nSEG <= 8'hFF;
            nAN  <= 4'hF;
        end else if (lit) begin
            nSEG <= ~pat;
            nAN  <= ~(4'b0001 << idx);
        end else begin
            nSEG <= 8'hFF;
            nAN  <= 4'hF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: random bus traffic against a cycle-level
// behavioural model of the display controller.
module tb_seg7_scan_ctrl;

    localparam logic [31:0] BASE = 32'hc000_0000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] nSEG;
    logic [3:0] nAN;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_dig [4];
    bit          m_en;
    int          m_bright;
    bit          m_hex;
    int          m_phase;
    logic [31:0] m_rdata;

    seg7_scan_ctrl_if bus();

    seg7_scan_ctrl #(
        .BASE_ADDR(BASE),
        .SCAN_BITS(3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus),
        .nSEG(nSEG),
        .nAN (nAN)
    );

    always #5 CLK = ~CLK;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] font(logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06;
            4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D;
            4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F;
            4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E;
            4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] shown(logic [7:0] d);
        if (m_hex) return {d[7], font(d[3:0])};
        return d;
    endfunction

    function automatic logic [31:0] reg_val(logic [31:0] ofs);
        if (ofs < 32'h10 && ofs[1:0] == 2'b00) return {24'h0, m_dig[ofs[3:2]]};
        if (ofs == 32'h10) return 32'(m_en) + 32'(m_bright * 2) + 32'(m_hex) * 16;
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 8'h00;
        m_en = 0;
        m_bright = 7;
        m_hex = 0;
        m_phase = 0;
        m_rdata = 0;
    endtask

    task automatic bus_idle();
        bus.IO_Addr_Strobe  = 1'b0;
        bus.IO_Read_Strobe  = 1'b0;
        bus.IO_Write_Strobe = 1'b0;
        bus.IO_Byte_Enable  = 4'h0;
    endtask

    // One clock: predict from pre-edge state, advance model, compare.
    task automatic step();
        bit          acc, rd, we;
        logic [31:0] ofs, wd;
        logic [7:0]  e_seg;
        logic [3:0]  e_an;
        int          dg;
        @(posedge CLK);
        acc = bus.IO_Addr_Strobe && (bus.IO_Read_Strobe || bus.IO_Write_Strobe);
        rd  = bus.IO_Addr_Strobe && bus.IO_Read_Strobe;
        we  = bus.IO_Addr_Strobe && bus.IO_Write_Strobe && bus.IO_Byte_Enable[0];
        ofs = bus.IO_Address - BASE;
        wd  = bus.IO_Write_Data;
        e_seg = 8'hFF;
        e_an  = 4'hF;
        if (m_en && (m_phase % 8) <= m_bright) begin
            dg = (m_phase / 8) % 4;
            e_an = 4'hF - 4'(2 ** dg);
            e_seg = ~shown(m_dig[dg]);
        end
        if (rd) m_rdata = reg_val(ofs);
        m_phase = m_en ? m_phase + 1 : 0;
        if (we) begin
            if (ofs < 32'h10 && ofs[1:0] == 2'b00) m_dig[ofs[3:2]] = wd[7:0];
            if (ofs == 32'h10) begin
                m_en = wd[0];
                m_bright = int'(wd[3:1]);
`ifdef SEG7_HEX_DECODE_EN
                m_hex = wd[4];
`endif
            end
        end
        #1;
        check("ready", 32'(bus.IO_Ready), 32'(acc));
        check("nAN", 32'(nAN), 32'(e_an));
        check("nSEG", 32'(nSEG), 32'(e_seg));
        check("rdata", bus.IO_Read_Data, m_rdata);
    endtask

    task automatic idle(int n);
        bus_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(logic [31:0] ofs, logic [31:0] data);
        bus.IO_Address      = BASE + ofs;
        bus.IO_Write_Data   = data;
        bus.IO_Byte_Enable  = 4'hF;
        bus.IO_Addr_Strobe  = 1'b1;
        bus.IO_Write_Strobe = 1'b1;
        bus.IO_Read_Strobe  = 1'b0;
        step();
        bus_idle();
    endtask

    task automatic bus_read(logic [31:0] ofs);
        bus.IO_Address      = BASE + ofs;
        bus.IO_Addr_Strobe  = 1'b1;
        bus.IO_Read_Strobe  = 1'b1;
        bus.IO_Write_Strobe = 1'b0;
        step();
        bus_idle();
    endtask

    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        check("rst_nSEG", 32'(nSEG), 32'hFF);
        check("rst_nAN", 32'(nAN), 32'hF);
        check("rst_ready", 32'(bus.IO_Ready), 32'h0);
        check("rst_rdata", bus.IO_Read_Data, 32'h0);
        model_reset();
        RST = 1'b0;
    endtask

    logic [31:0] addrs [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h40};

    initial begin
        int lit_cycles;
        int cur;
        logic [31:0] a, d;
        bus.IO_Address    = BASE;
        bus.IO_Write_Data = 32'h0;
        bus_idle();
        model_reset();
        #12;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        idle(10);
        bus_read(32'h10);
        check("ctrl_reset", bus.IO_Read_Data, 32'h0E);

        bus_write(32'h00, 32'h3F);
        bus_write(32'h04, 32'h06);
        bus_write(32'h08, 32'h5B);
        bus_write(32'h0C, 32'h4F);
        bus_write(32'h10, 32'h0F);
        check("scan_start", 32'(nAN), 32'hF);
        step();
        check("first_digit", 32'(nAN), 32'hE);
        idle(40);

        bus_write(32'h10, 32'h01);
        lit_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (nAN != 4'hF) lit_cycles++;
        end
        check("lit_count", 32'(lit_cycles), 32'd4);

        bus_write(32'h10, 32'h0F);
        bus_read(32'h08);
        check("rd_dig2", bus.IO_Read_Data, 32'h5B);
        bus_read(32'h40);
        check("rd_unmapped", bus.IO_Read_Data, 32'h0);
        bus_write(32'h40, 32'hFFFF_FFFF);
        for (int i = 0; i <= 16; i += 4) bus_read(i);

        idle(3);
        cur = (m_phase / 8) % 4;
        bus_write(32'(cur * 4), 32'h77);
        idle(20);
        async_reset();
        idle(5);

        bus_write(32'h00, 32'h8A);
        bus_write(32'h10, 32'h1F);
        step();
`ifdef SEG7_HEX_DECODE_EN
        check("hex_seg", 32'(nSEG), 32'h08);
`else
        check("raw_seg", 32'(nSEG), 32'h75);
`endif
        bus_read(32'h10);
`ifdef SEG7_HEX_DECODE_EN
        check("ctrl_hex", bus.IO_Read_Data, 32'h1F);
`else
        check("ctrl_nohex", bus.IO_Read_Data, 32'h0F);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = addrs[$urandom_range(0, 6)];
                d = $urandom();
                if (a == 32'h10 && $urandom_range(0, 4) != 0) d[0] = 1'b1;
                bus.IO_Address      = BASE + a;
                bus.IO_Write_Data   = d;
                bus.IO_Byte_Enable  = 4'($urandom_range(0, 15));
                bus.IO_Addr_Strobe  = ($urandom_range(0, 7) != 0);
                bus.IO_Read_Strobe  = $urandom_range(0, 1) == 1;
                bus.IO_Write_Strobe = !bus.IO_Read_Strobe;
                step();
            end else begin
                idle(1);
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
